ddr4_reset_n_seq: RTL and testbench
===================================

DDR4_RESET_N_SEQ -- requirements
Module: ddr4_reset_n_seq

Interface
REQ-001 Parameters SHALL be:
- T_RST_LOW, default 40000: FAB_CLK cycles RESET_N is held low.
- T_CKE_WAIT, default 100000: cycles from RESET_N release to CKE_ALLOWED.
- MOVE_GAP, default 4: idle cycles after each delay-line move pulse.
- Both timing parameters are in range 1..2^20-1.
REQ-002 Ports SHALL be as follows (name, direction, width, meaning):
- FAB_CLK  in  1  sole clock.
- ARST_N  in  1  asynchronous active-low reset.
- INIT_REQ  in  1  single-cycle pulse; restarts the reset sequence.
- TRIM_REQ  in  1  single-cycle pulse; starts a delay trim.
- TRIM_DIR  in  1  direction for the trim.
- TRIM_STEPS  in  8  number of moves in the trim.
- DELAY_LINE_OUT_OF_RANGE_0  in  1  out-of-range status from the IOD.
- TX_DATA_0  out  4  RESET_N serialized data to the IOD; bit 0 is first.
- OE_DATA_0  out  4  output enables to the IOD.
- DELAY_LINE_LOAD_0  out  1  delay-line load strobe.
- DELAY_LINE_MOVE_0  out  1  delay-line move strobe.
- DELAY_LINE_DIRECTION_0  out  1  delay-line move direction.
- CKE_ALLOWED  out  1  high once the memory may take CKE.
- TRIM_BUSY  out  1  high while a trim is running.
- TRIM_ERR  out  1  sticky trim error flag.
REQ-003 The block SHALL use one clock, FAB_CLK, and an asynchronous active-low reset, ARST_N.

Function
REQ-004 The main FSM SHALL have four states: LOAD, HOLD_LOW, WAIT_CKE and READY.
REQ-005 LOAD SHALL last one cycle, assert DELAY_LINE_LOAD_0 for that cycle, then go to HOLD_LOW.
REQ-006 HOLD_LOW SHALL drive TX_DATA_0=4'b0000 for exactly T_RST_LOW cycles, then go to WAIT_CKE.
REQ-007 In WAIT_CKE and READY, TX_DATA_0 SHALL be 4'b1111.
REQ-008 WAIT_CKE SHALL last exactly T_CKE_WAIT cycles, then go to READY.
REQ-009 CKE_ALLOWED SHALL be high only in READY, and SHALL be registered.
REQ-010 OE_DATA_0 SHALL be 4'b1111 in every state after reset release.
REQ-011 The state counter SHALL be 20 bits unsigned, load on state entry, count down, and exit at 1 (no wrap).
REQ-012 INIT_REQ in any state SHALL force LOAD on the next cycle, abort any trim, drop CKE_ALLOWED and clear TRIM_BUSY.
REQ-013 TRIM_REQ SHALL be accepted only in READY with TRIM_BUSY low; otherwise it SHALL be ignored with no flag change.
REQ-014 If INIT_REQ and TRIM_REQ occur together, INIT_REQ SHALL win and the trim SHALL be ignored.
REQ-015 On acceptance, the trim SHALL latch TRIM_DIR and TRIM_STEPS, clear TRIM_ERR and set TRIM_BUSY on the next cycle.
REQ-016 The trim FSM SHALL have three states: T_IDLE, T_MOVE and T_GAP.
REQ-017 T_MOVE SHALL pulse DELAY_LINE_MOVE_0 for one cycle, with DELAY_LINE_DIRECTION_0 held at the latched direction from acceptance until TRIM_BUSY falls.
REQ-018 T_GAP SHALL last MOVE_GAP cycles; at the end of the gap, the trim SHALL decrement the remaining count and return to T_MOVE if the count is nonzero, else go to T_IDLE.
REQ-019 If DELAY_LINE_OUT_OF_RANGE_0 is high in any T_GAP cycle, the trim SHALL set TRIM_ERR, issue no further moves, and return to T_IDLE at the end of that cycle.
REQ-020 TRIM_STEPS=0 SHALL give exactly one TRIM_BUSY cycle with no move pulse.
REQ-021 Every output SHALL be driven from a flop, with no combinational path from input to output.

Reset
REQ-022 While ARST_N is low, the outputs SHALL be:
- TX_DATA_0=4'b0000 and OE_DATA_0=4'b1111 (the memory sees RESET_N low).
- DELAY_LINE_LOAD_0=0, DELAY_LINE_MOVE_0=0, DELAY_LINE_DIRECTION_0=0.
- CKE_ALLOWED=0, TRIM_BUSY=0, TRIM_ERR=0.
- Main FSM in LOAD, trim FSM in T_IDLE, counters at 0.
REQ-023 Reset SHALL assert asynchronously and de-assert synchronized to FAB_CLK through a two-flop synchronizer.
REQ-024 The first cycle after synchronized release SHALL be LOAD.

Structure
REQ-025 Package ddr4_rst_pkg SHALL hold:
- the main FSM state enum and the trim FSM state enum;
- the counter width constant (20);
- the default values of T_RST_LOW, T_CKE_WAIT and MOVE_GAP.
REQ-026 The trim engine SHALL be the one sub-module, ddr4_dly_trim, which owns the T_* FSM, the move and direction outputs, TRIM_BUSY and TRIM_ERR.

Verification
REQ-027 The bench SHALL cover these directed scenarios, with T_RST_LOW=10, T_CKE_WAIT=20 and MOVE_GAP=2 unless stated:
- Reset release -> LOAD pulse in cycle 1, then 10 cycles of TX_DATA_0=0000, then 1111; CKE_ALLOWED rises 20 cycles after TX_DATA_0 goes to 1111.
- TRIM_REQ in READY with STEPS=3, DIR=1 -> three move pulses 3 cycles apart, DIRECTION=1 throughout, TRIM_BUSY falls after the last gap, TRIM_ERR=0.
- STEPS=5 with OUT_OF_RANGE raised in the second gap -> exactly 2 moves, TRIM_ERR=1, TRIM_BUSY falls; next accepted TRIM_REQ clears TRIM_ERR.
- INIT_REQ during the 2nd move of a trim -> LOAD next cycle, TRIM_BUSY=0, CKE_ALLOWED=0, then a full sequence repeats.
- TRIM_REQ during WAIT_CKE, and TRIM_REQ in the same cycle as INIT_REQ -> no move pulses, TRIM_ERR unchanged.
- ARST_N asserted mid-HOLD_LOW -> outputs reach reset values with no clock edge; after release, hold is a fresh 10 cycles.

Source files
------------

// File: rtl/ddr4_rst_pkg.sv
// ----------------------------------------------------------------------------
// ddr4_rst_pkg
// Shared types and constants for the DDR4 RESET_N sequencer.
//   - main_state_e : main FSM states (LOAD, HOLD_LOW, WAIT_CKE, READY)
//   - trim_state_e : delay-trim FSM states (T_IDLE, T_MOVE, T_GAP)
//   - CNT_W / cnt_t : width and type of the countdown timers
//   - *_DEF         : default timing values in FAB_CLK cycles
// ----------------------------------------------------------------------------
package ddr4_rst_pkg;

    localparam int unsigned CNT_W = 20;

    localparam int unsigned T_RST_LOW_DEF  = 40000;
    localparam int unsigned T_CKE_WAIT_DEF = 100000;
    localparam int unsigned MOVE_GAP_DEF   = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        HOLD_LOW = 2'd1,
        WAIT_CKE = 2'd2,
        READY    = 2'd3
    } main_state_e;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_MOVE = 2'd1,
        T_GAP  = 2'd2
    } trim_state_e;

endpackage

// File: rtl/ddr4_reset_n_seq_if.sv
// ----------------------------------------------------------------------------
// ddr4_reset_n_seq_if
// Request / IOD signal bundle of the DDR4 RESET_N sequencer.
//   master : the controller side (drives requests and IOD status)
//   slave  : the sequencer (drives IOD serial data, strobes and status flags)
// Signals:
//   INIT_REQ, TRIM_REQ, TRIM_DIR, TRIM_STEPS[7:0], DELAY_LINE_OUT_OF_RANGE_0
//   TX_DATA_0[3:0], OE_DATA_0[3:0], DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0,
//   DELAY_LINE_DIRECTION_0, CKE_ALLOWED, TRIM_BUSY, TRIM_ERR
// ----------------------------------------------------------------------------
interface ddr4_reset_n_seq_if;

    logic       INIT_REQ;
    logic       TRIM_REQ;
    logic       TRIM_DIR;
    logic [7:0] TRIM_STEPS;
    logic       DELAY_LINE_OUT_OF_RANGE_0;

    logic [3:0] TX_DATA_0;
    logic [3:0] OE_DATA_0;
    logic       DELAY_LINE_LOAD_0;
    logic       DELAY_LINE_MOVE_0;
    logic       DELAY_LINE_DIRECTION_0;
    logic       CKE_ALLOWED;
    logic       TRIM_BUSY;
    logic       TRIM_ERR;

    modport master (
        output INIT_REQ, TRIM_REQ, TRIM_DIR, TRIM_STEPS, DELAY_LINE_OUT_OF_RANGE_0,
        input  TX_DATA_0, OE_DATA_0, DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0,
               DELAY_LINE_DIRECTION_0, CKE_ALLOWED, TRIM_BUSY, TRIM_ERR
    );

    modport slave (
        input  INIT_REQ, TRIM_REQ, TRIM_DIR, TRIM_STEPS, DELAY_LINE_OUT_OF_RANGE_0,
        output TX_DATA_0, OE_DATA_0, DELAY_LINE_LOAD_0, DELAY_LINE_MOVE_0,
               DELAY_LINE_DIRECTION_0, CKE_ALLOWED, TRIM_BUSY, TRIM_ERR
    );

endinterface

// File: rtl/ddr4_dly_trim.sv
// ----------------------------------------------------------------------------
// ddr4_dly_trim
// Delay-line trim engine. Once accepted, issues TRIM_STEPS single-cycle move
// pulses, each followed by MOVE_GAP idle cycles. An out-of-range report during
// a gap stops the trim and sets the sticky error flag.
// Ports:
//   clk, rst_n      clock and (already synchronized) async active-low reset
//   abort           restart request from the main sequencer; kills any trim
//   ready           main sequencer is in READY
//   trim_req        single-cycle trim request
//   trim_dir        move direction, latched on acceptance
//   trim_steps      number of moves, latched on acceptance
//   out_of_range    IOD delay-line out-of-range status
//   dl_move         delay-line move strobe (registered)
//   dl_dir          delay-line direction (registered)
//   trim_busy       trim in progress (registered)
//   trim_err        sticky out-of-range error (registered)
// ----------------------------------------------------------------------------
module ddr4_dly_trim
    import ddr4_rst_pkg::*;
#(
    parameter int unsigned MOVE_GAP = MOVE_GAP_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       abort,
    input  logic       ready,
    input  logic       trim_req,
    input  logic       trim_dir,
    input  logic [7:0] trim_steps,
    input  logic       out_of_range,
    output logic       dl_move,
    output logic       dl_dir,
    output logic       trim_busy,
    output logic       trim_err
);

    localparam cnt_t GAP_LOAD = cnt_t'(MOVE_GAP);
    localparam cnt_t CNT_ONE  = cnt_t'(1);

    trim_state_e state_q, state_d;
    logic [7:0]  rem_q, rem_d;
    cnt_t        gap_q, gap_d;
    logic        dir_q, dir_d;
    logic        err_q, err_d;
    logic        busy_q;
    logic        move_q;
    logic        accept;
    logic        zero_trim;

    // busy_q covers every non-idle state, so a low busy_q also means T_IDLE.
    assign accept = trim_req && ready && !abort && !busy_q;

    // NOTE: every variable assigned below gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        gap_d     = gap_q;
        dir_d     = dir_q;
        err_d     = err_q;
        zero_trim = 1'b0;

        if (abort) begin
            state_d = T_IDLE;
            rem_d   = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                T_IDLE: begin
                    if (accept) begin
                        dir_d = trim_dir;
                        err_d = 1'b0;
                        rem_d = trim_steps;
                        if (trim_steps != 8'd0) begin
                            state_d = T_MOVE;
                        end else begin
                            // Zero-length trim: busy for the acceptance cycle only.
                            zero_trim = 1'b1;
                        end
                    end
                end

                T_MOVE: begin
                    state_d = T_GAP;
                    gap_d   = GAP_LOAD;
                end

                T_GAP: begin
                    if (out_of_range) begin
                        err_d   = 1'b1;
                        state_d = T_IDLE;
                        rem_d   = '0;
                        gap_d   = '0;
                    end else if (gap_q <= CNT_ONE) begin
                        rem_d   = rem_q - 8'd1;
                        gap_d   = '0;
                        state_d = (rem_q > 8'd1) ? T_MOVE : T_IDLE;
                    end else begin
                        gap_d = gap_q - CNT_ONE;
                    end
                end

                default: begin
                    state_d = T_IDLE;
                end
            endcase
        end
    end

    // Strobes are registered from the next state so they line up with the
    // state they describe while still coming straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= T_IDLE;
            rem_q   <= '0;
            gap_q   <= '0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            move_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
            busy_q  <= (state_d != T_IDLE) || zero_trim;
            move_q  <= (state_d == T_MOVE);
        end
    end

    assign dl_move   = move_q;
    assign dl_dir    = dir_q;
    assign trim_busy = busy_q;
    assign trim_err  = err_q;

endmodule

// File: rtl/ddr4_reset_n_seq.sv
// ----------------------------------------------------------------------------
// ddr4_reset_n_seq
// DDR4 RESET_N power-up sequencer with delay-line trim. After reset release
// it loads the IOD delay line, holds RESET_N low for T_RST_LOW cycles, waits
// T_CKE_WAIT cycles with RESET_N high and then raises CKE_ALLOWED. In READY a
// trim request steps the output delay line (see ddr4_dly_trim).
// Ports:
//   FAB_CLK   sole clock
//   ARST_N    asynchronous active-low reset (released through 2-flop sync)
//   bus       ddr4_reset_n_seq_if.slave: requests, IOD data/strobes, status
// ----------------------------------------------------------------------------
module ddr4_reset_n_seq
    import ddr4_rst_pkg::*;
#(
    parameter int unsigned T_RST_LOW  = T_RST_LOW_DEF,
    parameter int unsigned T_CKE_WAIT = T_CKE_WAIT_DEF,
    parameter int unsigned MOVE_GAP   = MOVE_GAP_DEF
) (
    input  logic               FAB_CLK,
    input  logic               ARST_N,
    ddr4_reset_n_seq_if.slave  bus
);

    localparam cnt_t CNT_ONE      = cnt_t'(1);
    localparam cnt_t HOLD_LOAD    = cnt_t'(T_RST_LOW);
    localparam cnt_t CKE_LOAD     = cnt_t'(T_CKE_WAIT);

    // ------------------------------------------------------------------------
    // Reset synchronizer: asserts immediately, releases two edges later.
    // ------------------------------------------------------------------------
    logic [1:0] rst_sync;
    logic       rst_n_sync;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge value of its neighbours.
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_sync = rst_sync[1];

    // ------------------------------------------------------------------------
    // Main sequencer
    // ------------------------------------------------------------------------
    main_state_e state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    logic [3:0]  tx_q;
    logic [3:0]  oe_q;
    logic        load_q;
    logic        cke_q;
    logic        in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;

        if (bus.INIT_REQ) begin
            state_d = LOAD;
            cnt_d   = CNT_ONE;
        end else begin
            case (state_q)
                LOAD: begin
                    // The counter is 0 only straight out of reset: that first
                    // clocked cycle enters LOAD properly instead of skipping it.
                    if (cnt_q == CNT_ONE) begin
                        state_d = HOLD_LOW;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        cnt_d   = CNT_ONE;
                    end
                end

                HOLD_LOW: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = WAIT_CKE;
                        cnt_d   = CKE_LOAD;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end

                WAIT_CKE: begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q - CNT_ONE;
                    end
                end

                READY: begin
                    state_d = READY;
                end
            endcase
        end
    end

    // Outputs are registered from the next state so each strobe is high in
    // the same cycle as the state it belongs to.
    always_ff @(posedge FAB_CLK or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            tx_q    <= 4'b0000;
            oe_q    <= 4'b1111;
            load_q  <= 1'b0;
            cke_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tx_q    <= ((state_d == WAIT_CKE) || (state_d == READY)) ? 4'b1111 : 4'b0000;
            oe_q    <= 4'b1111;
            load_q  <= (state_d == LOAD);
            cke_q   <= (state_d == READY);
        end
    end

    assign in_ready = (state_q == READY);

    // ------------------------------------------------------------------------
    // Trim engine
    // ------------------------------------------------------------------------
    logic trim_move;
    logic trim_dir_out;
    logic trim_busy;
    logic trim_err;

    ddr4_dly_trim #(
        .MOVE_GAP (MOVE_GAP)
    ) u_trim (
        .clk          (FAB_CLK),
        .rst_n        (rst_n_sync),
        .abort        (bus.INIT_REQ),
        .ready        (in_ready),
        .trim_req     (bus.TRIM_REQ),
        .trim_dir     (bus.TRIM_DIR),
        .trim_steps   (bus.TRIM_STEPS),
        .out_of_range (bus.DELAY_LINE_OUT_OF_RANGE_0),
        .dl_move      (trim_move),
        .dl_dir       (trim_dir_out),
        .trim_busy    (trim_busy),
        .trim_err     (trim_err)
    );

    assign bus.TX_DATA_0              = tx_q;
    assign bus.OE_DATA_0              = oe_q;
    assign bus.DELAY_LINE_LOAD_0      = load_q;
    assign bus.DELAY_LINE_MOVE_0      = trim_move;
    assign bus.DELAY_LINE_DIRECTION_0 = trim_dir_out;
    assign bus.CKE_ALLOWED            = cke_q;
    assign bus.TRIM_BUSY              = trim_busy;
    assign bus.TRIM_ERR               = trim_err;

endmodule

// File: tb/tb_ddr4_reset_n_seq.sv
// ----------------------------------------------------------------------------
// tb_ddr4_reset_n_seq
// Self-checking bench for ddr4_reset_n_seq with T_RST_LOW=10, T_CKE_WAIT=20,
// MOVE_GAP=2. Inputs change just after the falling edge; outputs are sampled
// on the falling edge. Expected trim behaviour is derived arithmetically from
// the step count, the gap length and the gap in which out-of-range is raised.
// ----------------------------------------------------------------------------
module tb_ddr4_reset_n_seq;

    localparam int unsigned T_RST = 10;
    localparam int unsigned T_CKE = 20;
    localparam int unsigned GAP   = 2;
    localparam int          PER   = GAP + 1;   // cycles from one move to the next

    logic FAB_CLK = 1'b0;
    logic ARST_N;

    ddr4_reset_n_seq_if bus ();

    ddr4_reset_n_seq #(
        .T_RST_LOW  (T_RST),
        .T_CKE_WAIT (T_CKE),
        .MOVE_GAP   (GAP)
    ) dut (
        .FAB_CLK (FAB_CLK),
        .ARST_N  (ARST_N),
        .bus     (bus)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int n_tests = 0;
    int n_fail  = 0;
    bit model_err;          // expected value of the sticky error flag

    int mon_moves;
    int mon_busy;
    int mon_err_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge FAB_CLK);
    endtask

    // One cycle, accumulating anything trim-related that must stay quiet.
    task automatic cyc_mon();
        cyc();
        mon_moves   += int'(bus.DELAY_LINE_MOVE_0);
        mon_busy    += int'(bus.TRIM_BUSY);
        mon_err_bad += (bus.TRIM_ERR !== model_err) ? 1 : 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " tx"},   32'(bus.TX_DATA_0),              32'h0);
        check({tag, " oe"},   32'(bus.OE_DATA_0),              32'hF);
        check({tag, " load"}, 32'(bus.DELAY_LINE_LOAD_0),      32'h0);
        check({tag, " move"}, 32'(bus.DELAY_LINE_MOVE_0),      32'h0);
        check({tag, " dir"},  32'(bus.DELAY_LINE_DIRECTION_0), 32'h0);
        check({tag, " cke"},  32'(bus.CKE_ALLOWED),            32'h0);
        check({tag, " busy"}, 32'(bus.TRIM_BUSY),              32'h0);
        check({tag, " err"},  32'(bus.TRIM_ERR),               32'h0);
    endtask

    // Full power-up sequence starting from reset release or an INIT_REQ pulse
    // already on the bus. load_lat: cycles until the LOAD strobe is expected.
    // trim_in_wait: if nonzero, a TRIM_REQ is issued that many cycles into
    // WAIT_CKE and must be ignored.
    task automatic run_sequence(input string tag, input int load_lat, input int trim_in_wait);
        int n      = 0;
        int hold   = 0;
        int wait_c = 0;
        mon_moves   = 0;
        mon_busy    = 0;
        mon_err_bad = 0;

        while (n < 16) begin
            cyc();
            n++;
            bus.INIT_REQ = 1'b0;
            bus.TRIM_REQ = 1'b0;
            if (bus.DELAY_LINE_LOAD_0 === 1'b1) break;
        end
        check({tag, " load_lat"},  32'(n), 32'(load_lat));
        check({tag, " load_tx"},   32'(bus.TX_DATA_0),         32'h0);
        check({tag, " load_cke"},  32'(bus.CKE_ALLOWED),       32'h0);
        check({tag, " load_busy"}, 32'(bus.TRIM_BUSY),         32'h0);
        check({tag, " load_move"}, 32'(bus.DELAY_LINE_MOVE_0), 32'h0);
        check({tag, " load_oe"},   32'(bus.OE_DATA_0),         32'hF);

        cyc();
        check({tag, " load_width"}, 32'(bus.DELAY_LINE_LOAD_0), 32'h0);
        while (bus.TX_DATA_0 === 4'h0 && hold < int'(T_RST) + 8) begin
            hold++;
            cyc_mon();
        end
        check({tag, " hold_len"}, 32'(hold), 32'(T_RST));
        check({tag, " tx_high"},  32'(bus.TX_DATA_0), 32'hF);

        while (bus.CKE_ALLOWED !== 1'b1 && wait_c < int'(T_CKE) + 8) begin
            if (trim_in_wait != 0 && wait_c == trim_in_wait) begin
                bus.TRIM_REQ   = 1'b1;
                bus.TRIM_STEPS = 8'($urandom_range(1, 5));
                bus.TRIM_DIR   = 1'($urandom_range(0, 1));
            end
            wait_c++;
            cyc_mon();
            bus.TRIM_REQ = 1'b0;
        end
        check({tag, " cke_wait"},  32'(wait_c), 32'(T_CKE));
        check({tag, " ready_tx"},  32'(bus.TX_DATA_0), 32'hF);
        check({tag, " quiet_mv"},  32'(mon_moves),   32'h0);
        check({tag, " quiet_bsy"}, 32'(mon_busy),    32'h0);
        check({tag, " err_keep"},  32'(mon_err_bad), 32'h0);
    endtask

    // One trim from READY. oor_gap: gap index (1-based) in which out-of-range
    // is raised, 0 for none. abort_move: move index at which INIT_REQ is
    // raised, 0 for none (the caller then runs the restart sequence).
    task automatic run_trim(input string tag, input int steps, input bit dir,
                            input int oor_gap, input int abort_move);
        bit oor_hit   = (oor_gap > 0) && (oor_gap <= steps);
        int moves_exp = oor_hit ? oor_gap : steps;
        int busy_exp  = (steps == 0) ? 1 : (oor_hit ? (oor_gap - 1) * PER + 2 : steps * PER);
        int win       = busy_exp + 4;
        int moves     = 0;
        int misplaced = 0;
        int busy_len  = 0;
        int dir_bad   = 0;

        bus.TRIM_REQ   = 1'b1;
        bus.TRIM_DIR   = dir;
        bus.TRIM_STEPS = 8'(steps);
        for (int t = 0; t < win; t++) begin
            cyc();
            bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
            if (t == 0) begin
                // Scramble the request inputs: the trim must use latched copies.
                bus.TRIM_REQ   = 1'b0;
                bus.TRIM_DIR   = ~dir;
                bus.TRIM_STEPS = 8'($urandom);
                check({tag, " err_clr"},  32'(bus.TRIM_ERR),  32'h0);
                check({tag, " busy_set"}, 32'(bus.TRIM_BUSY), 32'h1);
            end
            if (bus.DELAY_LINE_MOVE_0 === 1'b1) begin
                moves++;
                if (t % PER != 0) misplaced++;
            end
            if (bus.TRIM_BUSY === 1'b1) begin
                busy_len++;
                if (bus.DELAY_LINE_DIRECTION_0 !== dir) dir_bad++;
            end
            if (oor_hit && t == (oor_gap - 1) * PER + 1) begin
                bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b1;
            end
            if (abort_move != 0 && t == (abort_move - 1) * PER) begin
                bus.INIT_REQ = 1'b1;
                break;
            end
        end
        bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;

        check({tag, " misplaced"}, 32'(misplaced), 32'h0);
        check({tag, " dir_hold"},  32'(dir_bad),   32'h0);
        if (abort_move != 0) begin
            check({tag, " moves_pre_abort"}, 32'(moves), 32'(abort_move));
            model_err = 1'b0;
        end else begin
            check({tag, " moves"},    32'(moves),         32'(moves_exp));
            check({tag, " busy_len"}, 32'(busy_len),      32'(busy_exp));
            check({tag, " busy_end"}, 32'(bus.TRIM_BUSY), 32'h0);
            check({tag, " err"},      32'(bus.TRIM_ERR),  32'(oor_hit));
            model_err = oor_hit;
        end
    endtask

    initial begin
        int r_steps;
        int r_oor;
        bit r_dir;

        ARST_N                        = 1'b0;
        bus.INIT_REQ                  = 1'b0;
        bus.TRIM_REQ                  = 1'b0;
        bus.TRIM_DIR                  = 1'b0;
        bus.TRIM_STEPS                = 8'd0;
        bus.DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
        model_err                     = 1'b0;

        // Reset state, then release: two synchronizer edges, then LOAD.
        repeat (3) cyc();
        check_reset_outputs("por");
        ARST_N = 1'b1;
        run_sequence("boot", 3, 0);

        // Directed trims.
        run_trim("trim3", 3, 1'b1, 0, 0);
        run_trim("oor5",  5, 1'b0, 2, 0);
        run_trim("reclr", 2, 1'b1, 0, 0);

        // INIT_REQ during the second move of a trim.
        run_trim("abort", 4, 1'b1, 0, 2);
        run_sequence("abort_seq", 1, 0);

        // Ignored requests while the error flag is set: TRIM_REQ together with
        // INIT_REQ, and TRIM_REQ during WAIT_CKE.
        run_trim("oor_b", 3, 1'b1, 1, 0);
        bus.INIT_REQ   = 1'b1;
        bus.TRIM_REQ   = 1'b1;
        bus.TRIM_STEPS = 8'd3;
        run_sequence("init_trim", 1, 5);
        check("init_trim err_after", 32'(bus.TRIM_ERR), 32'(model_err));

        // Zero-length trim.
        run_trim("zero", 0, 1'b1, 0, 0);

        // Randomized trims.
        for (int i = 0; i < 12; i++) begin
            r_steps = int'($urandom_range(0, 6));
            r_dir   = 1'($urandom_range(0, 1));
            r_oor   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0;
            run_trim($sformatf("rnd%0d", i), r_steps, r_dir, r_oor, 0);
            repeat ($urandom_range(0, 3)) cyc();
        end

        // Asynchronous reset in the middle of HOLD_LOW, with error and
        // direction flags set beforehand.
        run_trim("oor_c", 2, 1'b1, 2, 0);
        bus.INIT_REQ = 1'b1;
        cyc();
        bus.INIT_REQ = 1'b0;
        repeat (4) cyc();
        check("mid_hold tx", 32'(bus.TX_DATA_0), 32'h0);
        #2 ARST_N = 1'b0;
        #1 check_reset_outputs("arst_async");
        repeat (2) cyc();
        ARST_N    = 1'b1;
        model_err = 1'b0;
        run_sequence("arst_seq", 3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
